// File: rtl/baud_pkg.sv
// Shared constants for the UART baud tick generator.
// The preset table holds Q.4 divisors for a 50 MHz clock at 16x oversampling.
package baud_pkg;

  localparam int DIV_W_DEF    = 16;
  localparam int FRAC_W_DEF   = 4;
  localparam int DIV_TOT_W    = DIV_W_DEF + FRAC_W_DEF;
  localparam int OVS_DEF      = 16;
  localparam int N_PRESET_DEF = 8;
  localparam int PRESET_IDX_W = $clog2(N_PRESET_DEF);
  localparam int MIN_DIV_INT  = 2;

  typedef logic [DIV_TOT_W-1:0] baud_div_t;

  // Index 0 is 9600 baud, index 7 is 921600 baud.
  localparam logic [0:N_PRESET_DEF-1][DIV_TOT_W-1:0] PRESET_TABLE = {
    20'd5208, 20'd2604, 20'd1302, 20'd868,
    20'd434,  20'd217,  20'd109,  20'd54
  };

  function automatic baud_div_t div_of(input logic [31:0] idx);
    if (idx < 32'(N_PRESET_DEF)) begin
      return PRESET_TABLE[idx[PRESET_IDX_W-1:0]];
    end
    return '0;
  endfunction

endpackage

// File: rtl/frac_divider.sv
// Fractional clock divider: emits one tick per oversample interval whose length
// is D_int cycles plus the carry of a fractional accumulator.
module frac_divider
  import baud_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    restart,
  input  logic [DIV_W+FRAC_W-1:0] div,
  output logic                    wrap,
  output logic                    tick
);

  localparam int CNT_W = DIV_W + 1;

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRAC_W:0]  frac_acc_q, frac_acc_d;
  logic             tick_q;
  logic [FRAC_W:0]  frac_sum;
  logic [CNT_W-1:0] len;

  always_comb begin
    frac_sum   = frac_acc_q + {1'b0, div[FRAC_W-1:0]};
    len        = {1'b0, div[DIV_W+FRAC_W-1:FRAC_W]} + CNT_W'(frac_sum[FRAC_W]);
    wrap       = enable & run_q & (cnt_q == len - CNT_W'(1));
    run_d      = run_q;
    cnt_d      = cnt_q;
    frac_acc_d = frac_acc_q;
    if (!enable) begin
      run_d      = 1'b0;
      cnt_d      = '0;
      frac_acc_d = '0;
    end else if (!run_q) begin
      // First enabled edge only arms the counter, so the first tick lands D_int edges later.
      run_d      = 1'b1;
      cnt_d      = '0;
      frac_acc_d = '0;
    end else if (restart) begin
      cnt_d      = '0;
      frac_acc_d = '0;
    end else if (wrap) begin
      cnt_d      = '0;
      frac_acc_d = {1'b0, frac_sum[FRAC_W-1:0]};
    end else begin
      cnt_d      = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      cnt_q      <= '0;
      frac_acc_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      run_q      <= run_d;
      cnt_q      <= cnt_d;
      frac_acc_q <= frac_acc_d;
      tick_q     <= wrap;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/baud_tick_gen.sv
// UART baud tick generator: oversample and bit strobes from a fractional divisor,
// with a one-deep config queue that only switches rate on a bit boundary.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int DIV_W    = DIV_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF,
  parameter int OVS      = OVS_DEF,
  parameter int N_PRESET = N_PRESET_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic                        cfg_direct,
  input  logic [$clog2(N_PRESET)-1:0] cfg_preset,
  input  logic [DIV_W+FRAC_W-1:0]     cfg_div,
  output logic                        cfg_err,
  output logic [DIV_W+FRAC_W-1:0]     cur_div,
  output logic                        tick_ovs,
  output logic                        tick_bd
);

  localparam int DW    = DIV_W + FRAC_W;
  localparam int OVS_W = $clog2(OVS);
  localparam int PW    = $clog2(N_PRESET);
  localparam logic [DW-1:0] RESET_DIV = DW'(PRESET_TABLE[0]);

  logic             pending_q, pending_d;
  logic [DW-1:0]    pend_div_q, pend_div_d;
  logic [DW-1:0]    cur_div_q, cur_div_d;
  logic [OVS_W-1:0] ovs_cnt_q, ovs_cnt_d;
  logic             tick_bd_q, tick_bd_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_ready_q, cfg_ready_d;

  logic [DW-1:0]    req_div;
  logic             preset_oob;
  logic             req_bad;
  logic             accept;
  logic             div_wrap;
  logic             div_tick;
  logic             ovs_last;
  logic             bd_edge;
  logic             apply;

  // A full power-of-two table leaves no index that can be out of range.
  generate
    if (N_PRESET < (1 << PW)) begin : g_oob
      assign preset_oob = (cfg_preset >= PW'(N_PRESET));
    end else begin : g_no_oob
      assign preset_oob = 1'b0;
    end
  endgenerate

  always_comb begin
    req_div  = cfg_direct ? cfg_div : DW'(div_of(32'(cfg_preset)));
    req_bad  = (!cfg_direct && preset_oob) ||
               (req_div[DW-1:FRAC_W] < DIV_W'(MIN_DIV_INT));
    accept   = cfg_valid & cfg_ready_q;
    ovs_last = (ovs_cnt_q == OVS_W'(OVS - 1));
    bd_edge  = div_wrap & ovs_last;
    apply    = pending_q & (~enable | bd_edge);

    pending_d  = pending_q;
    pend_div_d = pend_div_q;
    if (apply) begin
      pending_d = 1'b0;
    end else if (accept && !req_bad) begin
      pending_d  = 1'b1;
      pend_div_d = req_div;
    end

    cur_div_d = apply ? pend_div_q : cur_div_q;

    if (!enable) begin
      ovs_cnt_d = '0;
    end else if (div_wrap) begin
      ovs_cnt_d = ovs_cnt_q + OVS_W'(1);
    end else begin
      ovs_cnt_d = ovs_cnt_q;
    end

    tick_bd_d = bd_edge;
    cfg_err_d = accept & req_bad;
    // Ready stays low through the apply cycle itself and returns one cycle later.
    cfg_ready_d = ~(pending_d | apply);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q   <= 1'b0;
      pend_div_q  <= '0;
      cur_div_q   <= RESET_DIV;
      ovs_cnt_q   <= '0;
      tick_bd_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      pending_q   <= pending_d;
      pend_div_q  <= pend_div_d;
      cur_div_q   <= cur_div_d;
      ovs_cnt_q   <= ovs_cnt_d;
      tick_bd_q   <= tick_bd_d;
      cfg_err_q   <= cfg_err_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  frac_divider #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_divider (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .restart (apply),
    .div     (cur_div_q),
    .wrap    (div_wrap),
    .tick    (div_tick)
  );

  assign tick_ovs  = div_tick;
  assign tick_bd   = tick_bd_q;
  assign cfg_err   = cfg_err_q;
  assign cfg_ready = cfg_ready_q;
  assign cur_div   = cur_div_q;

endmodule
